// File: rtl/fsm_run_detect.sv
// Moore run-length detector: flags RUN_LEN consecutive identical qualified bits on ser_in.
// Optional saturating detection-event counter det_cnt is built only when FSM_RUN_CNT_EN is defined.
module fsm_run_detect #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             in_vld,
  input  logic [1:0]       pol,
  input  logic             ovl,
  output logic             det,
  output logic             run_bit
`ifdef FSM_RUN_CNT_EN
  ,
  output logic [CNT_W-1:0] det_cnt
`endif
);

  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] RUN_LEN_C = CW'(RUN_LEN);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DET} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_bit_q, run_bit_d;
  logic          qual;
  logic [CW-1:0] cnt_inc;
  logic          det_event;

  // pol 11 behaves like 00: either value qualifies
  always_comb begin
    case (pol)
      2'b01:   qual = ser_in;
      2'b10:   qual = ~ser_in;
      default: qual = 1'b1;
    endcase
  end

  assign cnt_inc = (cnt_q == RUN_LEN_C) ? RUN_LEN_C : cnt_q + ONE_C;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_bit_d = run_bit_q;
    if (in_vld) begin
      case (state_q)
        IDLE: begin
          state_d   = RUN;
          cnt_d     = ONE_C;
          run_bit_d = ser_in;
        end
        RUN: begin
          if (ser_in == run_bit_q) begin
            // A non-qualifying run parks at RUN_LEN until polarity lets it through
            cnt_d = cnt_inc;
            if ((cnt_inc == RUN_LEN_C) && qual) state_d = DET;
          end else begin
            cnt_d     = ONE_C;
            run_bit_d = ser_in;
          end
        end
        DET: begin
          if (!(ovl && (ser_in == run_bit_q))) begin
            state_d   = RUN;
            cnt_d     = ONE_C;
            run_bit_d = ser_in;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          run_bit_d = 1'b0;
        end
      endcase
    end
  end

  assign det_event = in_vld && (state_d == DET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      run_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_bit_q <= run_bit_d;
    end
  end

  assign det     = (state_q == DET);
  assign run_bit = run_bit_q;

`ifdef FSM_RUN_CNT_EN
  logic [CNT_W-1:0] det_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_cnt_q <= '0;
    end else if (det_event && (det_cnt_q != {CNT_W{1'b1}})) begin
      det_cnt_q <= det_cnt_q + 1'b1;
    end
  end

  assign det_cnt = det_cnt_q;
`else
  logic unused_event;
  assign unused_event = det_event;
`endif

endmodule

// File: tb/tb_fsm_run_detect.sv
// Directed bench for fsm_run_detect: four instances (RUN_LEN 2/3/4, and 2 with a 2-bit counter)
// share one stimulus stream and are checked every cycle against a run-length model.
module tb_fsm_run_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       in_vld;
  logic [1:0] pol;
  logic       ovl;
  logic [3:0] det_w;
  logic [3:0] run_bit_w;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  always #5 clk = ~clk;

`ifdef FSM_RUN_CNT_EN
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;
`endif

  fsm_run_detect #(.RUN_LEN(2), .CNT_W(8)) u_rl2 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .in_vld(in_vld), .pol(pol), .ovl(ovl),
    .det(det_w[0]), .run_bit(run_bit_w[0])
`ifdef FSM_RUN_CNT_EN
    , .det_cnt(cnt0)
`endif
  );
  fsm_run_detect #(.RUN_LEN(3), .CNT_W(8)) u_rl3 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .in_vld(in_vld), .pol(pol), .ovl(ovl),
    .det(det_w[1]), .run_bit(run_bit_w[1])
`ifdef FSM_RUN_CNT_EN
    , .det_cnt(cnt1)
`endif
  );
  fsm_run_detect #(.RUN_LEN(4), .CNT_W(8)) u_rl4 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .in_vld(in_vld), .pol(pol), .ovl(ovl),
    .det(det_w[2]), .run_bit(run_bit_w[2])
`ifdef FSM_RUN_CNT_EN
    , .det_cnt(cnt2)
`endif
  );
  fsm_run_detect #(.RUN_LEN(2), .CNT_W(2)) u_rl2_sat (
    .clk(clk), .rst(rst), .ser_in(ser_in), .in_vld(in_vld), .pol(pol), .ovl(ovl),
    .det(det_w[3]), .run_bit(run_bit_w[3])
`ifdef FSM_RUN_CNT_EN
    , .det_cnt(cnt3)
`endif
  );

  // Model: length of the current run of equal bits (unbounded) plus whether we sit in a detection
  int rl  [4] = '{2, 3, 4, 2};
  int cap [4] = '{255, 255, 255, 3};
  bit m_hist [4] = '{0, 0, 0, 0};
  bit m_last [4] = '{0, 0, 0, 0};
  int m_run  [4] = '{0, 0, 0, 0};
  bit m_det  [4] = '{0, 0, 0, 0};
  int m_cnt  [4] = '{0, 0, 0, 0};

  task automatic model_step(input int k, input bit b);
    bit q;
    q = (pol == 2'b01) ? b : (pol == 2'b10) ? !b : 1'b1;
    if (m_det[k]) begin
      if (!(ovl && b == m_last[k])) begin
        m_det[k] = 1'b0;
        m_run[k] = 1;
      end
    end else begin
      m_run[k] = (m_hist[k] && b == m_last[k]) ? m_run[k] + 1 : 1;
      m_det[k] = (m_run[k] >= rl[k]) && q;
    end
    m_hist[k] = 1'b1;
    m_last[k] = b;
    if (m_det[k] && m_cnt[k] < cap[k]) m_cnt[k] = m_cnt[k] + 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_hist[k] = 0; m_last[k] = 0; m_run[k] = 0; m_det[k] = 0; m_cnt[k] = 0;
      end
    end else if (in_vld) begin
      for (int k = 0; k < 4; k++) model_step(k, ser_in);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef FSM_RUN_CNT_EN
  function automatic int dut_cnt(input int k);
    case (k)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction
`endif

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cyc_det[%0d]", k), int'(det_w[k]), int'(m_det[k]));
      chk($sformatf("cyc_run_bit[%0d]", k), int'(run_bit_w[k]), int'(m_last[k]));
`ifdef FSM_RUN_CNT_EN
      chk($sformatf("cyc_det_cnt[%0d]", k), dut_cnt(k), m_cnt[k]);
`endif
    end
  end

  task automatic send(input logic b, input logic v);
    ser_in = b;
    in_vld = v;
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d: ser_in=%0d in_vld=%0d pol=%0d ovl=%0d det[3:0]=%b", txn, b, v, pol, ovl, det_w);
  endtask

  // Pins a hand-computed det value on both the DUT and the model
  task automatic lit(input int k, input int exp, input string name);
    chk({name, "_dut"}, int'(det_w[k]), exp);
    chk({name, "_model"}, int'(m_det[k]), exp);
  endtask

  task automatic do_reset();
    in_vld = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  int e1 [6] = '{0, 0, 1, 0, 0, 1};
  int e2 [6] = '{0, 0, 1, 1, 1, 1};
  int e3 [5] = '{0, 0, 0, 0, 1};
  int b3 [5] = '{0, 0, 0, 1, 1};

  initial begin
    rst = 1'b1; ser_in = 1'b0; in_vld = 1'b0; pol = 2'b00; ovl = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_det[%0d]", k), int'(det_w[k]), 0);
      chk($sformatf("reset_run_bit[%0d]", k), int'(run_bit_w[k]), 0);
    end

    // Non-overlapping run of six ones, RUN_LEN=3
    for (int i = 0; i < 6; i++) begin send(1'b1, 1'b1); lit(1, e1[i], "s1_det"); end
`ifdef FSM_RUN_CNT_EN
    chk("s1_cnt", int'(cnt1), 2);
`endif
    do_reset();

    // Overlapping, pol=11 acts as either value
    pol = 2'b11; ovl = 1'b1;
    for (int i = 0; i < 6; i++) begin send(1'b1, 1'b1); lit(1, e2[i], "s2_det"); end
`ifdef FSM_RUN_CNT_EN
    chk("s2_cnt", int'(cnt1), 4);
`endif
    do_reset();

    // Ones-only polarity, RUN_LEN=2
    pol = 2'b01; ovl = 1'b0;
    for (int i = 0; i < 5; i++) begin send(b3[i][0], 1'b1); lit(0, e3[i], "s3_det"); end
`ifdef FSM_RUN_CNT_EN
    chk("s3_cnt", int'(cnt0), 1);
`endif
    do_reset();

    // Stall in the middle of a run and after detection, RUN_LEN=3
    pol = 2'b00; ovl = 1'b0;
    send(1'b1, 1'b1); send(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin send(i[0], 1'b0); lit(1, 0, "s4_stall_det"); end
    send(1'b1, 1'b1); lit(1, 1, "s4_final_det");
    for (int i = 0; i < 3; i++) begin send(1'b0, 1'b0); lit(1, 1, "s4_hold_det"); end
    do_reset();

    // Async reset mid-run discards history, RUN_LEN=4
    for (int i = 0; i < 3; i++) begin send(1'b1, 1'b1); lit(2, 0, "s5_pre_det"); end
    do_reset();
    chk("s5_rst_det", int'(det_w[2]), 0);
    chk("s5_rst_run_bit", int'(run_bit_w[2]), 0);
    for (int i = 0; i < 3; i++) begin send(1'b1, 1'b1); lit(2, 0, "s5_post_det"); end
    send(1'b1, 1'b1); lit(2, 1, "s5_full_det");
    do_reset();

    // Counter saturation with overlap, RUN_LEN=2
    ovl = 1'b1;
    for (int i = 0; i < 10; i++) send(1'b1, 1'b1);
    lit(3, 1, "s6_det");
`ifdef FSM_RUN_CNT_EN
    chk("s6_cnt_sat", int'(cnt3), 3);
    chk("s6_cnt_wide", int'(cnt0), 9);
`endif
    do_reset();

    // Saturated non-qualifying run released by a polarity change
    pol = 2'b01; ovl = 1'b0;
    for (int i = 0; i < 3; i++) begin send(1'b0, 1'b1); lit(0, 0, "s7_blocked_det"); end
    pol = 2'b00;
    send(1'b0, 1'b1); lit(0, 1, "s7_released_det");
    do_reset();

    // Alternating bits never form a run but run_bit follows the input
    pol = 2'b10; ovl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(i[0], 1'b1);
      lit(0, 0, "s8_alt_det");
      chk("s8_run_bit", int'(run_bit_w[1]), int'(i[0]));
    end
    send(1'b1, 1'b1); lit(0, 0, "s8_ones_blocked_det");
    send(1'b0, 1'b1); send(1'b0, 1'b1); lit(0, 1, "s8_zero_det");

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
